// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the data-memory requester:
//   - default address/data widths and the default wait-cycle timeout
//   - width of the wait-cycle counter (large enough for TIMEOUT up to 255)
//   - FSM state encoding used by riscv_dmem_requester
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TIMEOUT = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } mem_state_t;

endpackage : riscv_mem_pkg

// File: rtl/riscv_mem_timeout_counter.sv
// ---------------------------------------------------------------------------
// riscv_mem_timeout_counter
// Counts wait cycles of an outstanding memory access.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (count -> 0)
//   i_clear    : synchronous clear, used when a new access is accepted
//   i_enable   : count this cycle (high while waiting on memory)
//   o_expired  : high during the TIMEOUT-th wait cycle of the access
// ---------------------------------------------------------------------------
module riscv_mem_timeout_counter
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // Count starts at 0 in the first wait cycle, so the TIMEOUT-th wait
  // cycle is the one where the count equals TIMEOUT-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      // Hold at LAST so the count can never wrap back to a small value.
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule : riscv_mem_timeout_counter

// File: rtl/riscv_dmem_requester.sv
// ---------------------------------------------------------------------------
// riscv_dmem_requester
// Turns MEM-stage load/store requests into strobed accesses to a DRAM
// latency model, stalls the pipeline while the access is outstanding and
// reports completion (optionally with a timeout error) with a one-cycle pulse.
//
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   core_rden / core_wren   : load / store request (store wins if both set)
//   core_addr / core_wdata  : request address and store data
//   core_rdata              : load data register, valid with done && !err
//   core_stall              : pipeline hold while the access is outstanding
//   core_done / core_err    : one-cycle completion pulse / timeout flag
//   mem_rden / mem_wren     : read / write strobes, decoded from state
//   mem_addr / mem_wdata    : address and store data latched at accept
//   mem_rdata / mem_ready   : DRAM read data and completion pulse
// ---------------------------------------------------------------------------
module riscv_dmem_requester
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_rden,
  input  logic              core_wren,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              core_done,
  output logic              core_err,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  mem_state_t        r_state;
  mem_state_t        w_state_next;
  logic              w_accept;
  logic              w_waiting;
  logic              w_expired;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_core_rdata;

  assign w_waiting = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);

  riscv_mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_accept),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (core_wren) begin
          w_state_next = ST_WR_WAIT;
          w_accept     = 1'b1;
        end else if (core_rden) begin
          w_state_next = ST_RD_WAIT;
          w_accept     = 1'b1;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        // mem_ready takes priority over an expiry in the same cycle.
        if (mem_ready || w_expired) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // Requests still present here belong to the access just completed.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: latched request, load data and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem_addr  <= core_addr;
        r_mem_wdata <= core_wdata;
        r_err       <= 1'b0;
      end
      if ((r_state == ST_RD_WAIT) && mem_ready) begin
        r_core_rdata <= mem_rdata;
      end
      if (w_waiting && !mem_ready && w_expired) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_rden   = (r_state == ST_RD_WAIT);
  assign mem_wren   = (r_state == ST_WR_WAIT);
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_rdata = r_core_rdata;
  assign core_done  = (r_state == ST_RESP);
  assign core_err   = (r_state == ST_RESP) && r_err;
  // Stall in IDLE is combinational so the MEM stage holds in the accept cycle.
  assign core_stall = w_waiting || ((r_state == ST_IDLE) && (core_rden || core_wren));

endmodule : riscv_dmem_requester

// File: tb/tb_riscv_dmem_requester.sv
// ---------------------------------------------------------------------------
// tb_riscv_dmem_requester
// Directed bench for riscv_dmem_requester with a 3-count DRAM latency model.
// ---------------------------------------------------------------------------
module tb_riscv_dmem_requester;

  logic        clk;
  logic        rst_n;
  logic        core_rden;
  logic        core_wren;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [63:0] core_rdata;
  logic        core_stall;
  logic        core_done;
  logic        core_err;
  logic        mem_rden;
  logic        mem_wren;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;

  logic        model_en;
  logic        model_ready;
  logic [2:0]  model_cnt;
  logic        force_ready;

  int n_cmp;
  int n_mis;

  riscv_dmem_requester #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_rden  (core_rden),
    .core_wren  (core_wren),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .core_done  (core_done),
    .core_err   (core_err),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: counts strobe cycles, pulses ready after the count reaches 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_cnt   <= '0;
      model_ready <= 1'b0;
    end else if (model_en && (mem_rden || mem_wren)) begin
      if (model_cnt == 3'd3) begin
        model_ready <= 1'b1;
        model_cnt   <= '0;
      end else begin
        model_ready <= 1'b0;
        model_cnt   <= model_cnt + 3'd1;
      end
    end else begin
      model_ready <= 1'b0;
      model_cnt   <= '0;
    end
  end

  assign mem_ready = model_ready || force_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle with no request; the done pulse must already be gone.
  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_done_off"}, 64'(core_done), 64'd0);
  endtask

  // Issue one request in IDLE and follow it until core_done (bounded).
  // Cycle 0 is the IDLE request cycle; force_at raises mem_ready during that cycle.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input int force_at,
                           output int done_at, output int rd_cnt, output int wr_cnt,
                           output logic err_at_done, output logic wdata_ok);
    core_rden  = rd;
    core_wren  = wr;
    core_addr  = addr;
    core_wdata = wdata;
    #1;
    check_eq("stall_on_req", 64'(core_stall), 64'd1);
    done_at     = -1;
    rd_cnt      = 0;
    wr_cnt      = 0;
    err_at_done = 1'b0;
    wdata_ok    = 1'b1;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      @(posedge clk); #1;
      core_rden   = 1'b0;
      core_wren   = 1'b0;
      force_ready = (c == force_at);
      if (mem_rden) rd_cnt++;
      if (mem_wren) wr_cnt++;
      if (mem_wren && (mem_wdata !== wdata)) wdata_ok = 1'b0;
      if (core_done) begin
        done_at     = c;
        err_at_done = core_err;
      end
    end
    force_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int   done_at, rd_cnt, wr_cnt, done_cnt, d1, d2;
    logic err_v, ok_v;

    n_cmp       = 0;
    n_mis       = 0;
    rst_n       = 1'b0;
    core_rden   = 1'b0;
    core_wren   = 1'b0;
    core_addr   = '0;
    core_wdata  = '0;
    mem_rdata   = '0;
    model_en    = 1'b1;
    force_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_rden",   64'(mem_rden),   64'd0);
    check_eq("rst_mem_wren",   64'(mem_wren),   64'd0);
    check_eq("rst_core_done",  64'(core_done),  64'd0);
    check_eq("rst_core_err",   64'(core_err),   64'd0);
    check_eq("rst_core_stall", 64'(core_stall), 64'd0);
    check_eq("rst_core_rdata", core_rdata,      64'd0);
    check_eq("rst_mem_addr",   mem_addr,        64'd0);
    check_eq("rst_mem_wdata",  mem_wdata,       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load 0x1000 -> 0xDEADBEEF_CAFEF00D
    mem_rdata = 64'hDEADBEEF_CAFEF00D;
    do_access(1'b1, 1'b0, 64'h1000, 64'h0, 0, done_at, rd_cnt, wr_cnt, err_v, ok_v);
    $display("load  addr=1000 done_at=%0d rden=%0d rdata=%h err=%0d", done_at, rd_cnt, core_rdata, err_v);
    check_eq("ld_done_cycle", 64'(done_at), 64'd6);
    check_eq("ld_rden_cycles", 64'(rd_cnt), 64'd5);
    check_eq("ld_wren_cycles", 64'(wr_cnt), 64'd0);
    check_eq("ld_err", 64'(err_v), 64'd0);
    check_eq("ld_rdata", core_rdata, 64'hDEADBEEF_CAFEF00D);
    check_eq("ld_mem_addr", mem_addr, 64'h1000);
    idle_cycle("ld");

    // Store 0x2008 <- 0x55; DRAM read data must not leak into core_rdata
    mem_rdata = 64'h1111;
    do_access(1'b0, 1'b1, 64'h2008, 64'h55, 0, done_at, rd_cnt, wr_cnt, err_v, ok_v);
    $display("store addr=2008 done_at=%0d wren=%0d rden=%0d err=%0d", done_at, wr_cnt, rd_cnt, err_v);
    check_eq("st_done_cycle", 64'(done_at), 64'd6);
    check_eq("st_wren_cycles", 64'(wr_cnt), 64'd5);
    check_eq("st_rden_cycles", 64'(rd_cnt), 64'd0);
    check_eq("st_wdata_stable", 64'(ok_v), 64'd1);
    check_eq("st_rdata_kept", core_rdata, 64'hDEADBEEF_CAFEF00D);
    check_eq("st_mem_addr", mem_addr, 64'h2008);
    check_eq("st_mem_wdata", mem_wdata, 64'h55);
    idle_cycle("st");

    // Both strobes requested: write path wins
    do_access(1'b1, 1'b1, 64'h3000, 64'hAA, 0, done_at, rd_cnt, wr_cnt, err_v, ok_v);
    $display("both  addr=3000 done_at=%0d wren=%0d rden=%0d", done_at, wr_cnt, rd_cnt);
    check_eq("both_wren_cycles", 64'(wr_cnt), 64'd5);
    check_eq("both_rden_cycles", 64'(rd_cnt), 64'd0);
    check_eq("both_done_cycle", 64'(done_at), 64'd6);
    check_eq("both_mem_addr", mem_addr, 64'h3000);
    idle_cycle("both");

    // Timeout: memory never answers
    model_en  = 1'b0;
    mem_rdata = 64'h2222;
    do_access(1'b1, 1'b0, 64'h5000, 64'h0, 0, done_at, rd_cnt, wr_cnt, err_v, ok_v);
    $display("tmo   addr=5000 done_at=%0d rden=%0d err=%0d", done_at, rd_cnt, err_v);
    check_eq("tmo_done_cycle", 64'(done_at), 64'd17);
    check_eq("tmo_rden_cycles", 64'(rd_cnt), 64'd16);
    check_eq("tmo_err", 64'(err_v), 64'd1);
    check_eq("tmo_rdata_kept", core_rdata, 64'hDEADBEEF_CAFEF00D);
    idle_cycle("tmo");
    check_eq("tmo_err_off", 64'(core_err), 64'd0);
    check_eq("tmo_stall_off", 64'(core_stall), 64'd0);

    // mem_ready while idle is ignored
    force_ready = 1'b1;
    mem_rdata   = 64'h3333;
    @(posedge clk); #1;
    force_ready = 1'b0;
    $display("idle  stray mem_ready rdata=%h done=%0d", core_rdata, core_done);
    check_eq("idle_rdy_rdata", core_rdata, 64'hDEADBEEF_CAFEF00D);
    check_eq("idle_rdy_done", 64'(core_done), 64'd0);
    check_eq("idle_rdy_rden", 64'(mem_rden), 64'd0);

    // mem_ready in the same cycle as expiry: ready wins, no error
    mem_rdata = 64'h77;
    do_access(1'b1, 1'b0, 64'h6000, 64'h0, 16, done_at, rd_cnt, wr_cnt, err_v, ok_v);
    $display("race  addr=6000 done_at=%0d err=%0d rdata=%h", done_at, err_v, core_rdata);
    check_eq("race_done_cycle", 64'(done_at), 64'd17);
    check_eq("race_err", 64'(err_v), 64'd0);
    check_eq("race_rdata", core_rdata, 64'h77);
    idle_cycle("race");
    model_en = 1'b1;

    // Reset in cycle 3 of a load
    mem_rdata = 64'h4444;
    core_rden = 1'b1;
    core_addr = 64'h7000;
    @(posedge clk); #1;
    core_rden = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rstmid_rden_before", 64'(mem_rden), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_rden_async", 64'(mem_rden), 64'd0);
    check_eq("rstmid_stall", 64'(core_stall), 64'd0);
    check_eq("rstmid_mem_addr", mem_addr, 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst_n = 1'b1;
      if (core_done) done_cnt++;
    end
    $display("rst   mid-access done pulses=%0d rdata=%h", done_cnt, core_rdata);
    check_eq("rstmid_no_done", 64'(done_cnt), 64'd0);
    check_eq("rstmid_rdata", core_rdata, 64'd0);
    do_access(1'b1, 1'b0, 64'h7000, 64'h0, 0, done_at, rd_cnt, wr_cnt, err_v, ok_v);
    $display("load  addr=7000 done_at=%0d rdata=%h err=%0d", done_at, core_rdata, err_v);
    check_eq("post_rst_done_cycle", 64'(done_at), 64'd6);
    check_eq("post_rst_rdata", core_rdata, 64'h4444);
    check_eq("post_rst_err", 64'(err_v), 64'd0);
    idle_cycle("post_rst");

    // Back-to-back loads with core_rden held high
    mem_rdata = 64'h5555;
    core_rden = 1'b1;
    core_addr = 64'h8000;
    rd_cnt    = 0;
    done_cnt  = 0;
    d1        = -1;
    d2        = -1;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (mem_rden) rd_cnt++;
      if (core_done) begin
        done_cnt++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (c == 7) begin
        check_eq("b2b_gap_rden", 64'(mem_rden), 64'd0);
        check_eq("b2b_gap_stall", 64'(core_stall), 64'd1);
      end
    end
    core_rden = 1'b0;
    $display("b2b   done@%0d,%0d count=%0d rden=%0d", d1, d2, done_cnt, rd_cnt);
    check_eq("b2b_first_done", 64'(d1), 64'd6);
    check_eq("b2b_second_done", 64'(d2), 64'd13);
    check_eq("b2b_done_count", 64'(done_cnt), 64'd2);
    check_eq("b2b_rden_cycles", 64'(rd_cnt), 64'd10);
    check_eq("b2b_rdata", core_rdata, 64'h5555);
    idle_cycle("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_riscv_dmem_requester

// File: doc/riscv_dmem_requester.md
RISCV_DMEM_REQUESTER -- requirements
Module: riscv_dmem_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum wait cycles for mem_ready (range 2..255).
REQ-004 Ports SHALL be:
  clk  input  1  single clock, all state on rising edge
  rst_n  input  1  asynchronous, active-low reset
  core_rden  input  1  load request from MEM stage
  core_wren  input  1  store request from MEM stage
  core_addr  input  ADDR_W  request address
  core_wdata  input  DATA_W  store data
  core_rdata  output  DATA_W  load data, valid when core_done=1 and core_err=0
  core_stall  output  1  hold pipeline while access is outstanding
  core_done  output  1  one-cycle completion pulse
  core_err  output  1  one-cycle timeout flag, coincident with core_done
  mem_rden  output  1  read strobe to DRAM latency model
  mem_wren  output  1  write strobe to DRAM latency model
  mem_addr  output  ADDR_W  latched address
  mem_wdata  output  DATA_W  latched store data
  mem_rdata  input  DATA_W  DRAM read data, sampled with mem_ready
  mem_ready  input  1  DRAM completion pulse

Function
REQ-005 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT, RESP.
REQ-006 IDLE: core_wren=1 -> WR_WAIT; else core_rden=1 -> RD_WAIT; else stay; core_wren wins when both set.
REQ-007 On leaving IDLE, SHALL latch core_addr into mem_addr and core_wdata into mem_wdata; both held stable until the next accepted request.
REQ-008 mem_rden SHALL be 1 exactly in RD_WAIT; mem_wren exactly in WR_WAIT; both registered-state decodes, never both 1.
REQ-009 RD_WAIT/WR_WAIT: mem_ready=1 sampled -> RESP; strobes therefore drop the cycle after mem_ready is seen, so the DRAM counter restarts from 0 on the next request.
REQ-010 In RD_WAIT, mem_ready=1 SHALL load mem_rdata into the core_rdata register; core_rdata otherwise holds its last value (writes never change it).
REQ-011 A wait-cycle counter SHALL clear on entering RD_WAIT/WR_WAIT and increment each wait cycle; reaching TIMEOUT without mem_ready -> RESP with error flag set; core_rdata unchanged.
REQ-012 mem_ready and counter expiry in the same cycle: mem_ready wins, no error.
REQ-013 RESP: core_done=1, core_err=error flag, core_stall=0 for exactly one cycle, then unconditionally IDLE; requests present during RESP are ignored (no retrigger of the completed access).
REQ-014 core_stall SHALL be 1 in RD_WAIT and WR_WAIT, and combinationally 1 in IDLE when core_rden or core_wren is 1; 0 otherwise.
REQ-015 mem_ready in IDLE or RESP SHALL be ignored (no state, data or flag change).
REQ-016 Request-to-done latency SHALL be (cycles from strobe rise to mem_ready) + 2; against the 3-count DRAM model: done 6 cycles after request in IDLE.
REQ-017 core_done and core_err SHALL be 0 in all states except RESP.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE, mem_rden=0, mem_wren=0, core_done=0, core_err=0, core_rdata=0, mem_addr=0, mem_wdata=0, wait counter=0, error flag=0, regardless of clock.
REQ-019 Reset mid-access SHALL abandon the access without any core_done pulse; first request after rst_n rises is accepted normally.

Structure
REQ-020 Package riscv_mem_pkg SHALL hold the FSM state encoding and default ADDR_W, DATA_W, TIMEOUT constants.
REQ-021 The wait counter SHALL be sub-module riscv_mem_timeout_counter (clear, enable, expired output, parameter TIMEOUT).

Verification
REQ-022 Load addr 0x1000, DRAM model returns 0xDEADBEEF_CAFEF00D -> mem_rden high 5 cycles, core_done at cycle 6, core_rdata=0xDEADBEEF_CAFEF00D, core_err=0.
REQ-023 Store addr 0x2008 data 0x55 -> mem_wren only, mem_wdata=0x55 stable throughout, core_done at cycle 6, core_rdata unchanged.
REQ-024 core_rden=core_wren=1 -> write path taken, mem_rden never asserted.
REQ-025 mem_ready tied 0, TIMEOUT=16 -> RESP after 16 wait cycles, core_done=core_err=1 one cycle, then IDLE.
REQ-026 rst_n low in cycle 3 of a load -> strobes drop asynchronously, no core_done; following load completes normally.
REQ-027 Back-to-back loads with core_rden held high -> exactly one access per completion, one IDLE cycle between accesses, DRAM counter restarts at 0 each time.
